uart_rx: RTL

Serial receiver for the UART path: recovers 8-bit frames from the `rx` line, with optional even parity, and presents each byte with a one-cycle strobe. It sits directly downstream of the UART transmitter, on the far end of its `tx` wire. It uses the transmitter's frame format: idle-high line, one low start bit, 8 data bits LSB first, optional parity bit, one high stop bit. Bit timing comes from an internal per-bit clock counter, so the same block serves both direct loopback and real baud rates.

---
 rtl/uart_rx.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : UART serial receiver. 8 data bits LSB first, optional even
//             parity, one stop bit. Bit timing from an internal clock-per-bit
//             counter; each frame reported with one-cycle valid/error strobes.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
  // Start bit is re-checked half a bit after the falling edge
  localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic          s1_q, s1_d, s2_q, s2_d, rx_prev_q, rx_prev_d;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          par_bad;

  // Received parity bit disagrees with even parity over the data byte
  assign par_bad = PARITY_EN && (par_q != ^shift_q);

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != ST_IDLE);

  // Next-state logic: synchronizer chain plus frame sequencing
  always_comb begin
    s1_d      = rx;
    s2_d      = s1_q;
    rx_prev_d = s2_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Only a high-to-low transition starts a frame, so a held-low line cannot retrigger
        if (rx_prev_q && !s2_q) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!s2_q) begin
            state_d = ST_DATA;
            idx_d   = 3'd0;
          end else begin
            // Line back high mid start bit: treat as a glitch, report nothing
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d[idx_q] = s2_q;
          cnt_d          = '0;
          if (idx_q == 3'd7) begin
            state_d = PARITY_EN ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          par_d   = s2_q;
          cnt_d   = '0;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = ST_IDLE;
          data_d  = shift_q;
          ferr_d  = !s2_q;
          perr_d  = par_bad;
          valid_d = s2_q && !par_bad;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; synchronizer flops reset to the idle (high) line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      rx_prev_q <= rx_prev_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

endmodule
`default_nettype wire
